atu_tune_scheduler: RTL and testbench

Arbitrates external-ATU tune requests from three sources: host command, front-panel button and automatic band-change retune. Sequences one tune cycle at a time and records the outcome. Sits between the control/command decoder and the ICOM AH-4 tuner sequencer: it drives that sequencer's `auto_tune` input, requests a reduced-power tune carrier from the TX path, and observes the AH-4 status line directly.

---
 rtl/atu_tune_scheduler_if.sv | 24 ++
 rtl/atu_tune_scheduler.sv | 176 +++++++++++++++++
 tb/tb_atu_tune_scheduler.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atu_tune_scheduler_if.sv
// rtl/atu_tune_scheduler_if.sv - request/status/grant signal bundle for the ATU tune scheduler
interface atu_tune_scheduler_if;
    logic       req_host;
    logic       req_panel;
    logic       band_changed;
    logic       band_retune_en;
    logic       ptt_busy;
    logic       atu_status;
    logic       auto_tune;
    logic       tune_carrier;
    logic [1:0] grant;
    logic       done;
    logic [1:0] result;

    modport master (
        output req_host, req_panel, band_changed, band_retune_en, ptt_busy, atu_status,
        input  auto_tune, tune_carrier, grant, done, result
    );

    modport slave (
        input  req_host, req_panel, band_changed, band_retune_en, ptt_busy, atu_status,
        output auto_tune, tune_carrier, grant, done, result
    );
endinterface

// File: rtl/atu_tune_scheduler.sv
// rtl/atu_tune_scheduler.sv - arbitrates host/panel/band ATU tune requests and sequences one tune cycle (band requester: ATU_BAND_RETUNE_EN)
module atu_tune_scheduler #(
    parameter int unsigned CLK_HZ   = 2500000,
    parameter int unsigned START_MS = 2000,
    parameter int unsigned TUNE_MS  = 10000,
    parameter int unsigned GAP_MS   = 500
) (
    input  logic                 clk,
    input  logic                 rst_n,
    atu_tune_scheduler_if.slave  bus
);
    localparam int unsigned DIV  = CLK_HZ / 1000 - 1;
    localparam int          PW   = (DIV < 2) ? 1 : $clog2(DIV + 1);
    localparam logic [PW-1:0] DIV_V   = PW'(DIV);
    localparam logic [13:0]   START_V = 14'(START_MS);
    localparam logic [13:0]   TUNE_V  = 14'(TUNE_MS);
    localparam logic [13:0]   GAP_V   = 14'(GAP_MS);

    localparam logic [1:0] G_NONE  = 2'b00;
    localparam logic [1:0] G_HOST  = 2'b01;
    localparam logic [1:0] G_PANEL = 2'b10;
    localparam logic [1:0] G_BAND  = 2'b11;

    localparam logic [1:0] R_OK      = 2'b00;
    localparam logic [1:0] R_NOSTART = 2'b01;
    localparam logic [1:0] R_TUNE_TO = 2'b10;
    localparam logic [1:0] R_ABORT   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_TUNING, S_COOLDOWN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic [13:0]   r_timer;
    logic          r_pend_panel;
    logic          r_host_armed;
    logic          w_pend_band;
    logic          r_auto_tune;
    logic          r_tune_carrier;
    logic          r_done;
    logic [1:0]    r_grant;
    logic [1:0]    r_result;
    logic          w_tick;
    logic          w_expired;
    logic          w_abort;
    logic          w_panel_set;
    logic [1:0]    w_sel;
    logic [1:0]    w_code;
    logic          w_auto_tune_nxt;
    logic          w_done_nxt;
    logic [1:0]    w_grant_nxt;
    logic [1:0]    w_result_nxt;

    assign w_tick      = (r_presc == DIV_V);
    assign w_expired   = w_tick && (r_timer == 14'd0);
    // r_grant is only non-zero in ARM/TUNING, so these terms cannot fire elsewhere
    assign w_abort     = ((r_grant == G_HOST) && !bus.req_host) ||
                         ((r_grant == G_PANEL) && bus.req_panel);
    // a press during a panel cycle is an abort, not a new request
    assign w_panel_set = bus.req_panel && (r_grant != G_PANEL);

    // free-running 1 ms prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_presc <= '0;
        else if (w_tick)  r_presc <= '0;
        else              r_presc <= r_presc + 1'b1;
    end

    // fixed-priority source selection; ptt only defers the non-host sources
    always_comb begin
        w_sel = G_NONE;
        if (bus.req_host && r_host_armed)        w_sel = G_HOST;
        else if (!bus.ptt_busy && r_pend_panel)  w_sel = G_PANEL;
        else if (!bus.ptt_busy && w_pend_band)   w_sel = G_BAND;
    end

    // panel pending flag; a new press wins over a same-cycle grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         r_pend_panel <= 1'b0;
        else if (w_panel_set)                               r_pend_panel <= 1'b1;
        else if (r_state == S_IDLE && w_sel == G_PANEL)     r_pend_panel <= 1'b0;
    end

`ifdef ATU_BAND_RETUNE_EN
    logic r_pend_band;

    // band-change pending flag; a new change wins over a same-cycle grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         r_pend_band <= 1'b0;
        else if (bus.band_changed && bus.band_retune_en)    r_pend_band <= 1'b1;
        else if (r_state == S_IDLE && w_sel == G_BAND)      r_pend_band <= 1'b0;
    end

    assign w_pend_band = r_pend_band;
`else
    logic w_band_unused;
    assign w_band_unused = bus.band_changed | bus.band_retune_en;
    assign w_pend_band   = 1'b0;
`endif

    // host edge re-arm: a level held across a finished cycle must drop before it counts again
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         r_host_armed <= 1'b1;
        else if (!bus.req_host)                             r_host_armed <= 1'b1;
        else if (r_state == S_IDLE && w_sel == G_HOST)      r_host_armed <= 1'b0;
    end

    // next state and outcome code; abort outranks status and timer events
    always_comb begin
        w_state_nxt = r_state;
        w_code      = r_result;
        case (r_state)
            S_IDLE: begin
                if (w_sel != G_NONE) w_state_nxt = S_ARM;
            end
            S_ARM: begin
                if (w_abort)             begin w_state_nxt = S_COOLDOWN; w_code = R_ABORT;   end
                else if (bus.atu_status) begin w_state_nxt = S_TUNING;                       end
                else if (w_expired)      begin w_state_nxt = S_COOLDOWN; w_code = R_NOSTART; end
            end
            S_TUNING: begin
                if (w_abort)             begin w_state_nxt = S_COOLDOWN; w_code = R_ABORT;   end
                else if (!bus.atu_status) begin w_state_nxt = S_COOLDOWN; w_code = R_OK;     end
                else if (w_expired)      begin w_state_nxt = S_COOLDOWN; w_code = R_TUNE_TO; end
            end
            S_COOLDOWN: begin
                if (w_expired) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // next values of the registered outputs, derived from the coming state
    always_comb begin
        w_auto_tune_nxt = (w_state_nxt == S_ARM) || (w_state_nxt == S_TUNING);
        w_grant_nxt     = G_NONE;
        if (r_state == S_IDLE && w_state_nxt == S_ARM) w_grant_nxt = w_sel;
        else if (w_auto_tune_nxt)                      w_grant_nxt = r_grant;
        w_done_nxt      = (w_state_nxt == S_COOLDOWN) && (r_state != S_COOLDOWN);
        w_result_nxt    = w_done_nxt ? w_code : r_result;
    end

    // state register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_auto_tune    <= 1'b0;
            r_tune_carrier <= 1'b0;
            r_grant        <= G_NONE;
            r_done         <= 1'b0;
            r_result       <= R_OK;
        end else begin
            r_state        <= w_state_nxt;
            r_auto_tune    <= w_auto_tune_nxt;
            r_tune_carrier <= w_auto_tune_nxt;
            r_grant        <= w_grant_nxt;
            r_done         <= w_done_nxt;
            r_result       <= w_result_nxt;
        end
    end

    // cycle timer: load on each state entry, otherwise count ms down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        r_timer <= 14'd0;
        else if (r_state == S_IDLE && w_state_nxt == S_ARM)  r_timer <= START_V;
        else if (r_state == S_ARM && w_state_nxt == S_TUNING) r_timer <= TUNE_V;
        else if (w_done_nxt)                               r_timer <= GAP_V;
        else if (w_tick && r_timer != 14'd0)               r_timer <= r_timer - 14'd1;
    end

    assign bus.auto_tune    = r_auto_tune;
    assign bus.tune_carrier = r_tune_carrier;
    assign bus.grant        = r_grant;
    assign bus.done         = r_done;
    assign bus.result       = r_result;
endmodule

// File: tb/tb_atu_tune_scheduler.sv
// tb/tb_atu_tune_scheduler.sv - self-checking bench for atu_tune_scheduler
module tb_atu_tune_scheduler;
    localparam int CLK_HZ = 10000;
    localparam int CPM    = CLK_HZ / 1000;
    localparam int S      = 20;
    localparam int T      = 60;
    localparam int G      = 5;
    localparam int NEVER  = 100000;
    localparam int LIMIT  = CPM * (S + T) + 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    atu_tune_scheduler_if bus();

    atu_tune_scheduler #(
        .CLK_HZ(CLK_HZ), .START_MS(S), .TUNE_MS(T), .GAP_MS(G)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        int src;
        int rise;
        int fall;
        int hdrop;
        int pabort;
        int res;
        int lo;
        int hi;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_win(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (bus.auto_tune) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic serve(input int rise, input int fall, input int hdrop, input int pabort,
                         output int dcyc, output int res);
        dcyc = -1;
        res  = -1;
        for (int c = 1; c <= LIMIT; c++) begin
            bus.atu_status = (c >= rise) && (c < fall);
            if (hdrop > 0 && c >= hdrop) bus.req_host = 1'b0;
            bus.req_panel = (c == pabort);
            step();
            if (bus.done) begin
                dcyc = c;
                res  = int'(bus.result);
                break;
            end
        end
        bus.atu_status = 1'b0;
        bus.req_panel  = 1'b0;
    endtask

    task automatic idle_wait();
        repeat (CPM * G + 20) step();
    endtask

    task automatic count_high(input int n, output int at, output int dn);
        at = 0;
        dn = 0;
        repeat (n) begin
            step();
            at += int'(bus.auto_tune);
            dn += int'(bus.done);
        end
    endtask

    int lat, dcyc, res, at_cnt, dn_cnt;
    int src, r, d, er, lo, hi;

    initial begin
        bus.req_host       = 1'b0;
        bus.req_panel      = 1'b0;
        bus.band_changed   = 1'b0;
        bus.band_retune_en = 1'b0;
        bus.ptt_busy       = 1'b0;
        bus.atu_status     = 1'b0;

        vt[0] = '{1, 7*CPM,  30*CPM, 0,   0,  0, 30*CPM,      30*CPM};
        vt[1] = '{2, NEVER,  NEVER,  0,   0,  1, CPM*S+1,     CPM*S+CPM};
        vt[2] = '{1, 5,      NEVER,  0,   0,  2, 5+CPM*T+1,   5+CPM*T+CPM};
        vt[3] = '{1, 20,     400,    100, 0,  3, 100,         100};
        vt[4] = '{2, NEVER,  NEVER,  0,   50, 3, 50,          50};
        vt[5] = '{1, NEVER,  NEVER,  30,  0,  3, 30,          30};
        vt[6] = '{2, 10,     50,     0,   0,  0, 50,          50};
        vt[7] = '{2, 10,     300,    0,   120, 3, 120,        120};

        #23;
        chk("rst_auto_tune", int'(bus.auto_tune), 0);
        chk("rst_tune_carrier", int'(bus.tune_carrier), 0);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_result", int'(bus.result), 0);
        step();
        rst_n = 1'b1;
        count_high(30, at_cnt, dn_cnt);
        chk("post_rst_no_grant", at_cnt, 0);

        // table-driven single cycles
        for (int i = 0; i < 8; i++) begin
            idle_wait();
            if (vt[i].src == 1) begin
                bus.req_host = 1'b1;
            end else begin
                bus.req_panel = 1'b1;
                step();
                bus.req_panel = 1'b0;
            end
            wait_grant(20, lat);
            chk($sformatf("v%0d_latency", i), lat, 1);
            chk($sformatf("v%0d_grant", i), int'(bus.grant), vt[i].src);
            chk($sformatf("v%0d_carrier_on", i), int'(bus.tune_carrier), 1);
            serve(vt[i].rise, vt[i].fall, vt[i].hdrop, vt[i].pabort, dcyc, res);
            chk($sformatf("v%0d_result", i), res, vt[i].res);
            chk_win($sformatf("v%0d_done_time", i), dcyc, vt[i].lo, vt[i].hi);
            chk($sformatf("v%0d_auto_tune_off", i), int'(bus.auto_tune), 0);
            chk($sformatf("v%0d_carrier_off", i), int'(bus.tune_carrier), 0);
            chk($sformatf("v%0d_grant_off", i), int'(bus.grant), 0);
            step();
            chk($sformatf("v%0d_done_single", i), int'(bus.done), 0);
            bus.req_host = 1'b0;
        end

        // host level held across done must not retrigger; a fresh edge does
        idle_wait();
        bus.req_host = 1'b1;
        wait_grant(20, lat);
        serve(5, 20, 0, 0, dcyc, res);
        chk("hold_first_result", res, 0);
        count_high(CPM * G + 40, at_cnt, dn_cnt);
        chk("hold_no_retrigger", at_cnt, 0);
        bus.req_host = 1'b0;
        step();
        bus.req_host = 1'b1;
        wait_grant(20, lat);
        chk("rearm_latency", lat, 1);
        serve(5, 20, 0, 0, dcyc, res);
        bus.req_host = 1'b0;

        // simultaneous requests: host, then panel, then band
        idle_wait();
        bus.req_host       = 1'b1;
        bus.req_panel      = 1'b1;
        bus.band_changed   = 1'b1;
        bus.band_retune_en = 1'b1;
        step();
        bus.req_panel    = 1'b0;
        bus.band_changed = 1'b0;
        chk("prio_first_on", int'(bus.auto_tune), 1);
        chk("prio_first_host", int'(bus.grant), 1);
        serve(3, 10, 0, 0, dcyc, res);
        bus.req_host = 1'b0;
        wait_grant(CPM * G + 30, lat);
        chk_win("prio_gap_panel", lat, CPM * G + 2, CPM * G + CPM + 1);
        chk("prio_second_panel", int'(bus.grant), 2);
        serve(3, 10, 0, 0, dcyc, res);
        wait_grant(CPM * G + 30, lat);
`ifdef ATU_BAND_RETUNE_EN
        chk_win("prio_gap_band", lat, CPM * G + 2, CPM * G + CPM + 1);
        chk("prio_third_band", int'(bus.grant), 3);
        serve(3, 10, 0, 0, dcyc, res);
`else
        chk("band_disabled_no_grant", lat, -1);
`endif
        bus.band_retune_en = 1'b0;

        // ptt defers the panel but not the host
        idle_wait();
        bus.ptt_busy  = 1'b1;
        bus.req_panel = 1'b1;
        step();
        bus.req_panel = 1'b0;
        count_high(CPM * G + 40, at_cnt, dn_cnt);
        chk("ptt_defers_panel", at_cnt, 0);
        bus.req_host = 1'b1;
        wait_grant(5, lat);
        chk("ptt_host_latency", lat, 1);
        chk("ptt_host_grant", int'(bus.grant), 1);
        serve(3, 10, 0, 0, dcyc, res);
        bus.req_host = 1'b0;
        count_high(CPM * G + 40, at_cnt, dn_cnt);
        chk("ptt_still_defers", at_cnt, 0);
        bus.ptt_busy = 1'b0;
        wait_grant(5, lat);
        chk("ptt_release_latency", lat, 1);
        chk("ptt_release_grant", int'(bus.grant), 2);
        serve(3, 10, 0, 0, dcyc, res);

        // randomized cycles against a window model
        for (int k = 0; k < 12; k++) begin
            src = int'($urandom_range(1, 2));
            do r = int'($urandom_range(1, CPM * S + 40)); while (r >= CPM * S + 1 && r <= CPM * S + CPM);
            do d = int'($urandom_range(1, CPM * T + 40)); while (d >= CPM * T + 1 && d <= CPM * T + CPM);
            if (r > CPM * S + CPM) begin
                er = 1; lo = CPM * S + 1; hi = CPM * S + CPM;
            end else if (d <= CPM * T) begin
                er = 0; lo = r + d; hi = r + d;
            end else begin
                er = 2; lo = r + CPM * T + 1; hi = r + CPM * T + CPM;
            end
            if (k == 0) idle_wait();
            bus.req_host = 1'b0;
            step();
            if (src == 1) begin
                bus.req_host = 1'b1;
            end else begin
                bus.req_panel = 1'b1;
                step();
                bus.req_panel = 1'b0;
            end
            wait_grant(CPM * G + 30, lat);
            if (k > 0) chk_win($sformatf("rnd%0d_gap", k), lat + 1 + (src == 2 ? 1 : 0), CPM * G + 2, CPM * G + CPM + 1);
            chk($sformatf("rnd%0d_grant", k), int'(bus.grant), src);
            serve(r, r + d, 0, 0, dcyc, res);
            chk($sformatf("rnd%0d_result", k), res, er);
            chk_win($sformatf("rnd%0d_done_time", k), dcyc, lo, hi);
        end
        bus.req_host = 1'b0;

        // reset in ARM: outputs drop at once, no done, pending flags lost
        idle_wait();
        bus.req_panel = 1'b1;
        step();
        bus.req_panel = 1'b0;
        wait_grant(20, lat);
        serve(NEVER, NEVER, 0, 5, dcyc, res);
        chk("pre_rst_abort", res, 3);
        idle_wait();
        bus.req_host = 1'b1;
        wait_grant(20, lat);
        chk("rst_seq_grant", int'(bus.grant), 1);
        bus.req_panel      = 1'b1;
        bus.band_changed   = 1'b1;
        bus.band_retune_en = 1'b1;
        step();
        bus.req_panel    = 1'b0;
        bus.band_changed = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arm_rst_auto_tune", int'(bus.auto_tune), 0);
        chk("arm_rst_tune_carrier", int'(bus.tune_carrier), 0);
        chk("arm_rst_grant", int'(bus.grant), 0);
        chk("arm_rst_done", int'(bus.done), 0);
        chk("arm_rst_result", int'(bus.result), 0);
        bus.req_host = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        count_high(CPM * (S + G) + 60, at_cnt, dn_cnt);
        chk("arm_rst_no_done", dn_cnt, 0);
        chk("arm_rst_pend_cleared", at_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
